// File: rtl/routing_table_initiator_prog_if.sv
// Lookup request/response handshake bundle for routing_table_initiator_prog.
// master = requesting side, slave = routing table.
interface routing_table_initiator_prog_if #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned PATH_WIDTH   = 7,
  parameter int unsigned TARGET_WIDTH = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_address;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [PATH_WIDTH-1:0]   resp_path;
  logic [TARGET_WIDTH-1:0] resp_target;
  logic                    resp_miss;

  modport master (
    output req_valid, req_address, resp_ready,
    input  req_ready, resp_valid, resp_path, resp_target, resp_miss
  );

  modport slave (
    input  req_valid, req_address, resp_ready,
    output req_ready, resp_valid, resp_path, resp_target, resp_miss
  );
endinterface

// File: rtl/routing_table_initiator_prog.sv
// Programmable address-range routing table with a single registered lookup stage.
// Optional miss counter (miss_count/miss_clear) is built only when ROUTING_MISS_COUNTER_EN is defined.
module routing_table_initiator_prog #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned PATH_WIDTH   = 7,
  parameter int unsigned TARGET_WIDTH = 4,
  parameter int unsigned NUM_RULES    = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cfg_we,
  input  logic [3:0]              cfg_idx,
  input  logic [ADDR_WIDTH-1:0]   cfg_base,
  input  logic [ADDR_WIDTH-1:0]   cfg_end,
  input  logic [PATH_WIDTH-1:0]   cfg_path,
  input  logic [TARGET_WIDTH-1:0] cfg_target,
  input  logic                    cfg_enable,
`ifdef ROUTING_MISS_COUNTER_EN
  output logic [15:0]             miss_count,
  input  logic                    miss_clear,
`endif
  routing_table_initiator_prog_if.slave bus
);

  logic [ADDR_WIDTH-1:0]   rule_base   [NUM_RULES];
  logic [ADDR_WIDTH-1:0]   rule_end    [NUM_RULES];
  logic [PATH_WIDTH-1:0]   rule_path   [NUM_RULES];
  logic [TARGET_WIDTH-1:0] rule_target [NUM_RULES];
  logic                    rule_enable [NUM_RULES];

  logic                    hit_found;
  logic [PATH_WIDTH-1:0]   hit_path;
  logic [TARGET_WIDTH-1:0] hit_target;
  logic                    accept;

  // Out-of-range indices simply match no entry, so they are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_RULES; i++) begin
        rule_base[i]   <= '0;
        rule_end[i]    <= '0;
        rule_path[i]   <= '0;
        rule_target[i] <= '0;
        rule_enable[i] <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_RULES; i++) begin
        if (cfg_we && cfg_idx == 4'(i)) begin
          rule_base[i]   <= cfg_base;
          rule_end[i]    <= cfg_end;
          rule_path[i]   <= cfg_path;
          rule_target[i] <= cfg_target;
          rule_enable[i] <= cfg_enable;
        end
      end
    end
  end

  // Priority scan: the first hit latches and blocks higher indices.
  always_comb begin
    hit_found  = 1'b0;
    hit_path   = '0;
    hit_target = '0;
    for (int unsigned i = 0; i < NUM_RULES; i++) begin
      if (!hit_found && rule_enable[i] &&
          bus.req_address >= rule_base[i] && bus.req_address < rule_end[i]) begin
        hit_found  = 1'b1;
        hit_path   = rule_path[i];
        hit_target = rule_target[i];
      end
    end
  end

  assign bus.req_ready = !bus.resp_valid || bus.resp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.resp_valid  <= 1'b0;
      bus.resp_path   <= '0;
      bus.resp_target <= '0;
      bus.resp_miss   <= 1'b0;
    end else if (accept) begin
      bus.resp_valid  <= 1'b1;
      bus.resp_path   <= hit_path;
      bus.resp_target <= hit_target;
      bus.resp_miss   <= !hit_found;
    end else if (bus.resp_ready) begin
      bus.resp_valid  <= 1'b0;
    end
  end

`ifdef ROUTING_MISS_COUNTER_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      miss_count <= '0;
    end else if (miss_clear) begin
      miss_count <= '0;
    end else if (bus.resp_valid && bus.resp_ready && bus.resp_miss && miss_count != '1) begin
      miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/routing_table_initiator_prog.md
ROUTING_TABLE_INITIATOR_PROG -- requirements
Module: routing_table_initiator_prog

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, lookup address width.
REQ-002 SHALL have parameter PATH_WIDTH, default 7, route encoding width; first hop in LSBs, last hop in MSBs.
REQ-003 SHALL have parameter TARGET_WIDTH, default 4, target NI id width.
REQ-004 SHALL have parameter NUM_RULES, default 4, legal range 1..16, rule table depth.
REQ-005 clock  in  1  single clock; all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 cfg_we  in  1  rule write strobe.
REQ-008 cfg_idx  in  4  rule index written.
REQ-009 cfg_base / cfg_end  in  ADDR_WIDTH each  inclusive base / exclusive end of the rule range.
REQ-010 cfg_path  in  PATH_WIDTH; cfg_target  in  TARGET_WIDTH; cfg_enable  in  1  rule payload.
REQ-011 req_valid  in  1; req_ready  out  1; req_address  in  ADDR_WIDTH  lookup request.
REQ-012 resp_valid  out  1; resp_ready  in  1  lookup response handshake.
REQ-013 resp_path  out  PATH_WIDTH; resp_target  out  TARGET_WIDTH; resp_miss  out  1  (failed decoding).
REQ-014 miss_count  out  16; miss_clear  in  1  present only under ROUTING_MISS_COUNTER_EN.

Function
REQ-015 Rule i hits when enable_i=1 and base_i <= address < end_i, unsigned compare; base >= end never hits.
REQ-016 Lowest-index hitting rule SHALL win.
REQ-017 No hit: resp_miss=1, resp_path=0, resp_target=0.
REQ-018 Request accepted when req_valid && req_ready; result SHALL appear on resp_* the next cycle with resp_valid=1 (latency 1).
REQ-019 req_ready SHALL equal !resp_valid || resp_ready (single output register, full throughput).
REQ-020 While resp_valid && !resp_ready, resp_* SHALL hold stable.
REQ-021 Response dequeued on resp_valid && resp_ready; resp_valid drops next cycle unless a new request is accepted in the same cycle.
REQ-022 cfg_we with cfg_idx < NUM_RULES SHALL update all fields of that rule at the clock edge; cfg_idx >= NUM_RULES SHALL be ignored.
REQ-023 Lookup accepted in the same cycle as a cfg write SHALL use the pre-write table; next accepted lookup sees the new rule.
REQ-024 Config writes SHALL be accepted regardless of request/response handshake state.

Reset
REQ-025 On reset_n low: all rules enable=0, base=0, end=0, path=0, target=0.
REQ-026 On reset_n low: resp_valid=0, resp_path=0, resp_target=0, resp_miss=0; req_ready=1 on the first cycle out of reset.
REQ-027 Reset mid-transaction SHALL drop any pending response; no response emitted for it after release.

Configuration
REQ-028 Macro ROUTING_MISS_COUNTER_EN defined: miss_count SHALL increment by 1 on each response dequeue with resp_miss=1, saturate at 16'hFFFF, reset to 0, and clear to 0 on miss_clear (clear wins over a simultaneous increment).
REQ-029 Macro undefined: miss_count and miss_clear ports and counter logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-030 Reset, program rule0 base 32'h10400000 end 32'h10800000 path 7'b0000001 target 4'h5, lookup 32'h10400000 -> next cycle resp_valid=1, path 7'b0000001, target 4'h5, miss=0.
REQ-031 Same table, lookup 32'h107fffff -> hit rule0; lookup 32'h10800000 -> miss=1, path 0, target 0.
REQ-032 Rules 0 and 1 both cover 32'h1a000000 with targets 4'hc and 4'h8 -> target 4'hc; disable rule0 -> target 4'h8.
REQ-033 Back-to-back requests with resp_ready held 0 for 3 cycles -> req_ready=0, resp_* stable; release -> one response per cycle, no loss or duplication.
REQ-034 cfg_we to rule0 in the same cycle a lookup is accepted -> old result returned; next lookup returns new result; cfg_idx=15 with NUM_RULES=4 -> table unchanged.
REQ-035 With ROUTING_MISS_COUNTER_EN: 3 dequeued misses -> miss_count=3; miss_clear with a simultaneous miss dequeue -> 0; preload to 16'hFFFF via 65535 misses, one more -> stays 16'hFFFF.
